// File: rtl/imem_loader_pkg.sv
// Shared types, defaults and small helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int DEFAULT_ADDR_W    = 10;
  localparam int DEFAULT_MAX_WORDS = 1024;
  localparam int HDR_BYTES         = 2;
  localparam int COUNT_W           = 11;

  // A header word count is usable only when non-zero and within the memory.
  function automatic logic count_ok(input logic [COUNT_W-1:0] n,
                                    input int unsigned        max_words);
    return (n != {COUNT_W{1'b0}}) && ({21'd0, n} <= max_words);
  endfunction

  function automatic logic [7:0] xsum_step(input logic [7:0] acc,
                                           input logic [7:0] data_byte);
    return acc ^ data_byte;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted payload bytes little-endian into a 32-bit word and keeps
// a running XOR of every payload byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_full,
  output logic [7:0]  xsum
);

  logic [1:0]  idx_r;
  logic [31:0] word_r;
  logic [7:0]  xsum_r;

  // Byte lane index and checksum; a restart drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= 2'd0;
      xsum_r <= 8'd0;
    end else if (clear) begin
      idx_r  <= 2'd0;
      xsum_r <= 8'd0;
    end else if (byte_en) begin
      idx_r  <= idx_r + 2'd1;
      xsum_r <= xsum_step(xsum_r, data_byte);
    end
  end

  // Lane data; holds its last value so the write data stays stable between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= 32'd0;
    end else if (byte_en && !clear) begin
      word_r[8*idx_r +: 8] <= data_byte;
    end
  end

  assign word      = word_r;
  assign xsum      = xsum_r;
  assign word_full = byte_en && (idx_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes it to instruction memory,
// verifies the checksum and holds the core until a load has passed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [31:0]        mem_wd,
  output logic               cpu_hold,
  output logic               busy,
  output logic               load_ok,
  output logic               load_err,
  output logic [COUNT_W-1:0] words_written
);

  state_t              state_r, state_nx_s;
  logic [7:0]          nlo_r;
  logic [COUNT_W-1:0]  n_r;
  logic [COUNT_W-1:0]  word_idx_r;
  logic [ADDR_W-1:0]   ld_addr_r;

  logic rx_ready_r, mem_we_r, busy_r, load_ok_r, load_err_r, cpu_hold_r;
  logic rx_ready_nx_s, mem_we_nx_s, busy_nx_s, load_ok_nx_s, load_err_nx_s, cpu_hold_nx_s;

  logic [31:0]        word_s;
  logic               word_full_s;
  logic [7:0]         xsum_s;
  logic               xfer_s;
  logic [COUNT_W-1:0] hdr_n_s;
  logic               last_word_s;

  // A restart always wins over a byte offered in the same cycle.
  assign xfer_s      = rx_valid && rx_ready_r && !load_start;
  assign hdr_n_s     = {rx_data[2:0], nlo_r};
  assign last_word_s = ((word_idx_r + 11'd1) == n_r);

  imem_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load_start),
    .byte_en   (xfer_s && (state_r == DATA)),
    .data_byte (rx_data),
    .word      (word_s),
    .word_full (word_full_s),
    .xsum      (xsum_s)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    if (load_start) begin
      state_nx_s = HDR0;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = IDLE;
        HDR0:    state_nx_s = xfer_s ? HDR1 : HDR0;
        HDR1: begin
          if (xfer_s) begin
            state_nx_s = count_ok(hdr_n_s, MAX_WORDS) ? DATA : ERR;
          end else begin
            state_nx_s = HDR1;
          end
        end
        DATA:    state_nx_s = (xfer_s && word_full_s) ? WRITE : DATA;
        WRITE:   state_nx_s = last_word_s ? CHK : DATA;
        CHK: begin
          if (xfer_s) begin
            state_nx_s = (rx_data == xsum_s) ? IDLE : ERR;
          end else begin
            state_nx_s = CHK;
          end
        end
        ERR:     state_nx_s = ERR;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    rx_ready_nx_s = 1'b0;
    mem_we_nx_s   = 1'b0;
    busy_nx_s     = 1'b0;
    case (state_nx_s)
      HDR0, HDR1, DATA, CHK: begin
        rx_ready_nx_s = 1'b1;
        busy_nx_s     = 1'b1;
      end
      WRITE: begin
        mem_we_nx_s = 1'b1;
        busy_nx_s   = 1'b1;
      end
      default: begin
        rx_ready_nx_s = 1'b0;
        mem_we_nx_s   = 1'b0;
        busy_nx_s     = 1'b0;
      end
    endcase

    load_ok_nx_s  = load_ok_r;
    load_err_nx_s = load_err_r;
    cpu_hold_nx_s = cpu_hold_r;
    if (load_start) begin
      load_ok_nx_s  = 1'b0;
      load_err_nx_s = 1'b0;
      cpu_hold_nx_s = 1'b1;
    end else if ((state_nx_s == ERR) && (state_r != ERR)) begin
      load_err_nx_s = 1'b1;
    end else if ((state_r == CHK) && (state_nx_s == IDLE)) begin
      load_ok_nx_s  = 1'b1;
      cpu_hold_nx_s = 1'b0;
    end else begin
      load_ok_nx_s  = load_ok_r;
      load_err_nx_s = load_err_r;
      cpu_hold_nx_s = cpu_hold_r;
    end
  end

  // Registered handshake, write strobe and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_r <= 1'b0;
      mem_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      load_ok_r  <= 1'b0;
      load_err_r <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      rx_ready_r <= rx_ready_nx_s;
      mem_we_r   <= mem_we_nx_s;
      busy_r     <= busy_nx_s;
      load_ok_r  <= load_ok_nx_s;
      load_err_r <= load_err_nx_s;
      cpu_hold_r <= cpu_hold_nx_s;
    end
  end

  // Header capture, word index and loader address (wraps modulo the memory size).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nlo_r      <= 8'd0;
      n_r        <= {COUNT_W{1'b0}};
      word_idx_r <= {COUNT_W{1'b0}};
      ld_addr_r  <= BASE_ADDR;
    end else if (load_start) begin
      word_idx_r <= {COUNT_W{1'b0}};
      ld_addr_r  <= BASE_ADDR;
    end else begin
      if ((state_r == HDR0) && xfer_s) begin
        nlo_r <= rx_data;
      end
      if ((state_r == HDR1) && xfer_s) begin
        n_r <= hdr_n_s;
      end
      if (state_r == WRITE) begin
        word_idx_r <= word_idx_r + 11'd1;
        ld_addr_r  <= ld_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rx_ready      = rx_ready_r;
  assign mem_we        = mem_we_r;
  assign mem_wd        = word_s;
  assign busy          = busy_r;
  assign load_ok       = load_ok_r;
  assign load_err      = load_err_r;
  assign cpu_hold      = cpu_hold_r;
  assign words_written = word_idx_r;
  assign mem_addr      = busy_r ? ld_addr_r : pc_addr;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames with random payloads
// checked against a frame-level model of the expected memory image and status.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int              AW   = 10;
  localparam logic [AW-1:0]   BASE = 10'd0;
  localparam int              MAXW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic [AW-1:0] pc_addr = 10'd0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic          cpu_hold, busy, load_ok, load_err;
  logic [10:0]   words_written;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] mem_obs [0:1023];
  int          we_cnt    = 0;
  int          rdy_in_wr = 0;
  logic [31:0] words [$];
  bit          gap = 1'b0;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .pc_addr(pc_addr), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
    .cpu_hold(cpu_hold), .busy(busy), .load_ok(load_ok), .load_err(load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory fed by the DUT's write port.
  always @(posedge clk) begin
    if (mem_we) begin
      mem_obs[mem_addr] <= mem_wd;
      we_cnt <= we_cnt + 1;
      if (rx_ready) rdy_in_wr <= rdy_in_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  function automatic logic [7:0] model_xsum();
    logic [7:0]  x = 8'd0;
    logic [31:0] w;
    foreach (words[i]) begin
      w = words[i];
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_b("rx_ready_timeout", rx_ready, 1'b1);
    @(posedge clk);
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    rx_valid   = 1'b0;
  endtask

  task automatic send_payload_bytes(input int count);
    logic [31:0] w;
    for (int i = 0; i < count; i++) begin
      w = words[i / 4];
      send_byte(w[8*(i % 4) +: 8]);
    end
  endtask

  // Header, payload of the queued words (only for a usable count), checksum.
  task automatic send_frame(input logic [10:0] n_hdr, input bit force_csum, input logic [7:0] csum_val);
    send_byte(n_hdr[7:0]);
    send_byte({5'd0, n_hdr[10:8]});
    if (n_hdr != 11'd0 && int'(n_hdr) <= MAXW) begin
      send_payload_bytes(4 * words.size());
      send_byte(force_csum ? csum_val : model_xsum());
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int            bad = 0;
    logic [AW-1:0] a;
    foreach (words[i]) begin
      a = BASE + AW'(i);
      if (mem_obs[a] !== words[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    int we0, rw0, n;

    // Reset values
    repeat (2) @(negedge clk);
    check_b("rst_rx_ready", rx_ready, 1'b0);
    check_b("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_load_ok", load_ok, 1'b0);
    check_b("rst_load_err", load_err, 1'b0);
    check("rst_words_written", {21'd0, words_written}, 32'd0);
    check_b("rst_cpu_hold", cpu_hold, 1'b1);
    rst_n = 1'b1;

    // Known two-word frame
    words = '{32'h0000_0013, 32'hDEAD_BEEF};
    pc_addr = 10'h155;
    we0 = we_cnt; rw0 = rdy_in_wr;
    pulse_start();
    check_b("start_busy", busy, 1'b1);
    check("start_addr_loader", {22'd0, mem_addr}, {22'd0, BASE});
    send_frame(11'd2, 1'b0, 8'h00);
    check_b("ok_load_ok", load_ok, 1'b1);
    check_b("ok_cpu_hold", cpu_hold, 1'b0);
    check_b("ok_busy", busy, 1'b0);
    check_b("ok_load_err", load_err, 1'b0);
    check("ok_words_written", {21'd0, words_written}, 32'd2);
    check("ok_we_count", we_cnt - we0, 2);
    check("ok_mem0", mem_obs[BASE], 32'h0000_0013);
    check("ok_mem1", mem_obs[BASE + 10'd1], 32'hDEAD_BEEF);
    check("ok_rdy_in_write", rdy_in_wr - rw0, 0);
    pc_addr = 10'($urandom);
    @(negedge clk);
    check("ok_addr_follows_pc", {22'd0, mem_addr}, {22'd0, pc_addr});

    // Same frame, wrong checksum
    pulse_start();
    check_b("restart_cpu_hold", cpu_hold, 1'b1);
    check_b("restart_load_ok", load_ok, 1'b0);
    send_frame(11'd2, 1'b1, 8'h00);
    check_b("bad_load_err", load_err, 1'b1);
    check_b("bad_cpu_hold", cpu_hold, 1'b1);
    check_b("bad_busy", busy, 1'b0);
    check("bad_words_written", {21'd0, words_written}, 32'd2);

    // Unusable word counts: zero and one past the maximum
    for (int t = 0; t < 2; t++) begin
      we0 = we_cnt;
      pulse_start();
      send_frame(t == 0 ? 11'd0 : 11'(MAXW + 1), 1'b0, 8'h00);
      check_b("hdr_load_err", load_err, 1'b1);
      check_b("hdr_busy", busy, 1'b0);
      check_b("hdr_rx_ready", rx_ready, 1'b0);
      check_b("hdr_cpu_hold", cpu_hold, 1'b1);
      check("hdr_no_write", we_cnt - we0, 0);
    end

    // Valid stalled every other cycle
    random_words(3);
    gap = 1'b1;
    we0 = we_cnt; rw0 = rdy_in_wr;
    pulse_start();
    send_frame(11'd3, 1'b0, 8'h00);
    gap = 1'b0;
    check_b("gap_load_ok", load_ok, 1'b1);
    check("gap_we_count", we_cnt - we0, 3);
    check("gap_rdy_in_write", rdy_in_wr - rw0, 0);
    check_mem("gap_mem");

    // Restart after six payload bytes; the byte under load_start is dropped
    random_words(2);
    pulse_start();
    send_byte(8'd2);
    send_byte(8'd0);
    send_payload_bytes(6);
    pulse_start();
    check("abort_words_written", {21'd0, words_written}, 32'd0);
    check_b("abort_busy", busy, 1'b1);
    random_words(1);
    we0 = we_cnt;
    send_frame(11'd1, 1'b0, 8'h00);
    check("abort_we_count", we_cnt - we0, 1);
    check("abort_mem_base", mem_obs[BASE], words[0]);
    check("abort_words_written_new", {21'd0, words_written}, 32'd1);
    check_b("abort_load_ok", load_ok, 1'b1);

    // Asynchronous reset mid-word
    random_words(2);
    pulse_start();
    send_byte(8'd2);
    send_byte(8'd0);
    send_payload_bytes(5);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_b("arst_busy", busy, 1'b0);
    check_b("arst_cpu_hold", cpu_hold, 1'b1);
    check_b("arst_mem_we", mem_we, 1'b0);
    check_b("arst_rx_ready", rx_ready, 1'b0);
    check("arst_mem_wd", mem_wd, 32'd0);
    check("arst_words_written", {21'd0, words_written}, 32'd0);
    check("arst_addr_pc", {22'd0, mem_addr}, {22'd0, pc_addr});
    repeat (2) @(negedge clk);
    check_b("arst_hold_mem_we", mem_we, 1'b0);
    rst_n = 1'b1;

    // Random loads, then the largest allowed frame
    for (int r = 0; r < 4; r++) begin
      n = (r == 3) ? MAXW : int'($urandom_range(1, 6));
      random_words(n);
      gap = (r < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      we0 = we_cnt;
      pulse_start();
      send_frame(11'(n), 1'b0, 8'h00);
      gap = 1'b0;
      check_b("rnd_load_ok", load_ok, 1'b1);
      check("rnd_words_written", {21'd0, words_written}, n);
      check("rnd_we_count", we_cnt - we0, n);
      check_mem("rnd_mem");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net in case the stimulus itself stalls.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
